// File: rtl/pll_spi_master_if.sv
// Command/response bus of the PLL SPI master: the requester uses the master
// modport, the SPI engine uses the slave modport.
interface pll_spi_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/pll_spi_master.sv
// SPI mode-0 master for PLL register access: one 40-bit frame per command
// ({rw, addr[6:0], data[31:0]}, MSB first) with a chip-select guard gap between frames.
module pll_spi_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_IDLE = 4
) (
  input  logic            clock,
  input  logic            reset,
  pll_spi_master_if.slave bus,
  output logic            spi_sck,
  output logic            spi_cs_n,
  output logic            spi_mosi,
  input  logic            spi_miso
);

  localparam int unsigned FRAME_W = 40;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BIT_W   = 6;

  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(CS_IDLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    HOLD,
    GUARD
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [FRAME_W-1:0]  tx_sr;
  logic [DATA_W-1:0]   rx_sr;
  logic                rw_q;
  logic                half_done_c;

  assign half_done_c = (tick_cnt == HALF_LAST);

  // tick_cnt times both SCK half-periods and the CS guard gap
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      rw_q          <= 1'b0;
      spi_sck       <= 1'b0;
      spi_cs_n      <= 1'b1;
      spi_mosi      <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.busy      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
          if (bus.cmd_valid && bus.cmd_ready) begin
            state         <= SETUP;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            spi_cs_n      <= 1'b0;
            spi_mosi      <= bus.cmd_rw;
            rw_q          <= bus.cmd_rw;
            tx_sr         <= {bus.cmd_rw, bus.cmd_addr,
                              (bus.cmd_rw ? {DATA_W{1'b0}} : bus.cmd_wdata)};
            tick_cnt      <= '0;
            bit_cnt       <= '0;
          end
        end

        SETUP: begin
          if (half_done_c) begin
            state    <= SCK_HI;
            spi_sck  <= 1'b1;
            rx_sr    <= {rx_sr[DATA_W-2:0], spi_miso};
            bit_cnt  <= bit_cnt + 1'b1;
            tick_cnt <= '0;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        // MOSI advances on the falling SCK edge; zeros shift in behind the frame
        SCK_HI: begin
          if (half_done_c) begin
            state    <= SCK_LO;
            spi_sck  <= 1'b0;
            spi_mosi <= tx_sr[FRAME_W-2];
            tx_sr    <= {tx_sr[FRAME_W-2:0], 1'b0};
            tick_cnt <= '0;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        SCK_LO: begin
          if (half_done_c) begin
            tick_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state    <= HOLD;
              spi_mosi <= 1'b0;
            end else begin
              state   <= SCK_HI;
              spi_sck <= 1'b1;
              rx_sr   <= {rx_sr[DATA_W-2:0], spi_miso};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (half_done_c) begin
            state         <= GUARD;
            spi_cs_n      <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= rw_q ? rx_sr : {DATA_W{1'b0}};
            tick_cnt      <= '0;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        GUARD: begin
          if (tick_cnt == GUARD_LAST) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            tick_cnt      <= '0;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_spi_master.sv
// Bench for pll_spi_master: cycle-level timeline model plus SPI slave register model,
// directed write/read/back-to-back/abort/ignored-command scenarios.
module tb_pll_spi_master;

  localparam int D0 = 2;
  localparam int G0 = 4;
  localparam int D1 = 1;
  localparam int G1 = 4;
  localparam int L0 = 82 * D0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pll_spi_master_if bus0 ();
  pll_spi_master_if bus1 ();

  logic sck0, cs0, mosi0;
  logic miso0 = 1'b0;
  logic sck1, cs1, mosi1;
  logic miso1 = 1'b0;

  pll_spi_master #(.CLK_DIV(D0), .CS_IDLE(G0)) u0 (
    .clock(clock), .reset(reset), .bus(bus0),
    .spi_sck(sck0), .spi_cs_n(cs0), .spi_mosi(mosi0), .spi_miso(miso0)
  );

  pll_spi_master #(.CLK_DIV(D1), .CS_IDLE(G1)) u1 (
    .clock(clock), .reset(reset), .bus(bus1),
    .spi_sck(sck1), .spi_cs_n(cs1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // literal expectations posted by the stimulus, drained by the compare process
  string       nm_q[$];
  logic [63:0] act_q[$];
  logic [63:0] exp_q[$];

  task automatic post(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nm_q.push_back(nm);
    act_q.push_back(act);
    exp_q.push_back(exp);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- SPI slave register model (u0) ----------------
  logic [31:0] regs [0:127];
  bit          s_init = 1'b0;
  int          s_bit = 0;
  int          s_frames = 0;
  logic [39:0] s_sh = '0;
  logic [39:0] s_last = '0;
  logic        s_rw = 1'b0;
  logic [6:0]  s_addr = '0;
  logic        p_sck0 = 1'b0;
  logic        p_cs0 = 1'b1;

  always @(negedge clock) begin
    if (!s_init) begin
      for (int i = 0; i < 128; i++) regs[i] = '0;
      regs[1] = 32'h02AB_CDEF;
      s_init = 1'b1;
    end
    if (cs0 === 1'b0 && p_cs0 === 1'b1) s_bit = 0;
    if (sck0 === 1'b1 && p_sck0 === 1'b0) begin
      s_sh = {s_sh[38:0], mosi0};
      s_bit++;
      if (s_bit == 8) begin
        s_rw   = s_sh[7];
        s_addr = s_sh[6:0];
      end
    end
    if (sck0 === 1'b0 && p_sck0 === 1'b1)
      miso0 = (s_bit >= 8 && s_bit < 40 && s_rw) ? regs[s_addr][39 - s_bit] : 1'b0;
    // a write commits only after all 40 bits arrived
    if (cs0 === 1'b1 && p_cs0 === 1'b0 && s_bit == 40) begin
      s_last = s_sh;
      s_frames++;
      if (!s_sh[39]) regs[s_sh[38:32]] = s_sh[31:0];
    end
    p_sck0 = sck0;
    p_cs0  = cs0;
  end

  // ---------------- run-length monitors ----------------
  int          lo0 = 0, last_lo0 = 0, rsp0_cnt = 0;
  int          lo1 = 0, hi1 = 0, c1_bits = 0;
  bit          c1_seen = 1'b0;
  logic [39:0] c1_sh = '0;
  logic        p_sck1 = 1'b0, p_cs1 = 1'b1;
  int          lo1_q[$], hi1_q[$];
  logic [39:0] w1_q[$];

  always @(negedge clock) begin
    if (sck1 === 1'b1 && p_sck1 === 1'b0) begin
      c1_sh = {c1_sh[38:0], mosi1};
      c1_bits++;
    end
    if (cs1 === 1'b0) begin
      if (p_cs1 === 1'b1) begin
        if (c1_seen) hi1_q.push_back(hi1);
        c1_bits = 0;
      end
      lo1++;
      hi1 = 0;
    end else begin
      if (p_cs1 === 1'b0) begin
        lo1_q.push_back(lo1);
        if (c1_bits == 40) w1_q.push_back(c1_sh);
        c1_seen = 1'b1;
      end
      lo1 = 0;
      hi1++;
    end
    if (cs0 === 1'b0) lo0++;
    else begin
      if (lo0 != 0) last_lo0 = lo0;
      lo0 = 0;
    end
    if (bus0.rsp_valid === 1'b1) rsp0_cnt++;
    p_sck1 = sck1;
    p_cs1  = cs1;
  end

  // ---------------- timeline model of u0 ----------------
  int          cyc = 0;
  int          r = 0;
  int          t0 = 0;
  bit          act = 1'b0;
  int          m_acc = 0;
  logic [39:0] m_frame = '0;
  logic [31:0] m_snap = '0;
  logic [31:0] m_rdata = '0;

  function automatic bit m_ready(input int x);
    if (x == r) return 1'b0;
    if (act && x >= t0 && (x - t0) < L0 + G0) return 1'b0;
    return 1'b1;
  endfunction

  // cycle index c = interval following the c-th rising edge
  always @(posedge clock) begin
    bit rdy;
    rdy = m_ready(cyc);
    cyc++;
    if (reset) begin
      r       = cyc;
      act     = 1'b0;
      m_rdata = '0;
    end else begin
      if (act && cyc == t0 + L0) m_rdata = m_frame[39] ? m_snap : 32'h0;
      if (rdy && bus0.cmd_valid === 1'b1) begin
        t0      = cyc;
        act     = 1'b1;
        m_acc++;
        m_frame = {bus0.cmd_rw, bus0.cmd_addr, (bus0.cmd_rw ? 32'h0 : bus0.cmd_wdata)};
        m_snap  = regs[bus0.cmd_addr];
      end
    end
  end

  // compare process: every cycle of u0, plus posted literal expectations
  always @(negedge clock) begin
    logic e_sck, e_cs, e_mosi, e_busy, e_rdy, e_rsp;
    int k, h, j;
    while (nm_q.size() > 0) chk(nm_q.pop_front(), act_q.pop_front(), exp_q.pop_front());
    if (cyc > 0) begin
      e_sck = 1'b0; e_cs = 1'b1; e_mosi = 1'b0; e_busy = 1'b0; e_rsp = 1'b0;
      e_rdy = m_ready(cyc);
      if (act && cyc >= t0) begin
        k = cyc - t0;
        if (k < L0) begin
          e_cs   = 1'b0;
          e_busy = 1'b1;
          if (k < D0) e_mosi = m_frame[39];
          else if (k < 81 * D0) begin
            h = (k - D0) / D0;
            j = h / 2;
            if (h % 2 == 0) begin
              e_sck  = 1'b1;
              e_mosi = m_frame[39 - j];
            end else begin
              e_mosi = (j == 39) ? 1'b0 : m_frame[38 - j];
            end
          end
        end else if (k < L0 + G0) begin
          e_busy = 1'b1;
          e_rsp  = (k == L0);
        end
      end
      chk("cyc_sck", 64'(sck0), 64'(e_sck));
      chk("cyc_cs_n", 64'(cs0), 64'(e_cs));
      chk("cyc_mosi", 64'(mosi0), 64'(e_mosi));
      chk("cyc_busy", 64'(bus0.busy), 64'(e_busy));
      chk("cyc_ready", 64'(bus0.cmd_ready), 64'(e_rdy));
      chk("cyc_rsp_valid", 64'(bus0.rsp_valid), 64'(e_rsp));
      chk("cyc_rsp_rdata", 64'(bus0.rsp_rdata), 64'(m_rdata));
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue0(input logic rw, input logic [6:0] a, input logic [31:0] d);
    int n;
    bit ok;
    n  = m_acc;
    ok = 1'b0;
    bus0.cmd_rw    = rw;
    bus0.cmd_addr  = a;
    bus0.cmd_wdata = d;
    bus0.cmd_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock);
      if (m_acc != n) ok = 1'b1;
    end
    bus0.cmd_valid = 1'b0;
    post("accept", 64'(ok), 64'(1));
  endtask

  task automatic wait_rsp0(output logic [31:0] d);
    bit ok;
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clock);
      if (bus0.rsp_valid === 1'b1) begin
        ok = 1'b1;
        d  = bus0.rsp_rdata;
      end
    end
    post("rsp_seen", 64'(ok), 64'(1));
  endtask

  task automatic wait_busy1(input logic lvl, input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clock);
      if (bus1.busy === lvl) ok = 1'b1;
    end
    post("busy1_wait", 64'(ok), 64'(1));
  endtask

  initial begin
    logic [31:0] d;
    int n, c;
    bit ok;
    bus0.cmd_valid = 1'b0; bus0.cmd_rw = 1'b0; bus0.cmd_addr = '0; bus0.cmd_wdata = '0;
    bus1.cmd_valid = 1'b0; bus1.cmd_rw = 1'b0; bus1.cmd_addr = '0; bus1.cmd_wdata = '0;

    // reset values
    repeat (3) @(negedge clock);
    post("rst_cs_n", 64'(cs0), 64'(1));
    post("rst_sck", 64'(sck0), 64'(0));
    post("rst_ready", 64'(bus0.cmd_ready), 64'(0));
    post("rst_busy", 64'(bus0.busy), 64'(0));
    post("rst_rdata", 64'(bus0.rsp_rdata), 64'(0));
    reset = 1'b0;
    @(negedge clock);
    post("ready_after_rst", 64'(bus0.cmd_ready), 64'(1));

    // back-to-back writes on the CLK_DIV=1 instance
    bus1.cmd_rw = 1'b0; bus1.cmd_addr = 7'h05; bus1.cmd_wdata = 32'h0000_00C3;
    bus1.cmd_valid = 1'b1;
    wait_busy1(1'b1, 50);
    bus1.cmd_addr = 7'h06; bus1.cmd_wdata = 32'h0000_3C00;
    wait_busy1(1'b0, 400);
    wait_busy1(1'b1, 50);
    bus1.cmd_valid = 1'b0;
    wait_busy1(1'b0, 400);
    repeat (3) @(negedge clock);
    post("b2b_frames", 64'(lo1_q.size()), 64'(2));
    if (lo1_q.size() == 2) begin
      post("b2b_low0", 64'(lo1_q[0]), 64'(82));
      post("b2b_low1", 64'(lo1_q[1]), 64'(82));
    end
    post("b2b_gaps", 64'(hi1_q.size()), 64'(1));
    if (hi1_q.size() >= 1) post("b2b_high", 64'(hi1_q[0]), 64'(5));
    if (w1_q.size() == 2) begin
      post("b2b_word0", 64'(w1_q[0]), 64'(40'h05_0000_00C3));
      post("b2b_word1", 64'(w1_q[1]), 64'(40'h06_0000_3C00));
    end else post("b2b_words", 64'(w1_q.size()), 64'(2));

    // write addr 0 = 0x15
    n = s_frames;
    issue0(1'b0, 7'h00, 32'h0000_0015);
    wait_rsp0(d);
    post("wr_rdata", 64'(d), 64'(0));
    repeat (4) @(negedge clock);
    post("wr_frames", 64'(s_frames), 64'(n + 1));
    post("wr_frame_bits", 64'(s_last), 64'(40'h00_0000_0015));
    post("wr_div", 64'(regs[0][3:0]), 64'(5));
    post("wr_enable", 64'(regs[0][4]), 64'(1));
    post("wr_cs_low", 64'(last_lo0), 64'(164));

    // read addr 1
    issue0(1'b1, 7'h01, 32'hFFFF_FFFF);
    wait_rsp0(d);
    post("rd_rdata", 64'(d), 64'(32'h02AB_CDEF));
    repeat (4) @(negedge clock);
    post("rd_addr_byte", 64'(s_last[39:32]), 64'(8'h81));
    post("rd_data_bits", 64'(s_last[31:0]), 64'(0));

    // command pulsed while busy is ignored
    n = s_frames;
    issue0(1'b0, 7'h02, 32'hA5A5_0F0F);
    repeat (30) @(negedge clock);
    bus0.cmd_rw = 1'b1; bus0.cmd_addr = 7'h03; bus0.cmd_wdata = 32'hDEAD_BEEF;
    bus0.cmd_valid = 1'b1;
    @(negedge clock);
    bus0.cmd_valid = 1'b0;
    wait_rsp0(d);
    post("ign_rdata", 64'(d), 64'(0));
    repeat (4) @(negedge clock);
    post("ign_frame_bits", 64'(s_last), 64'(40'h02_A5A5_0F0F));
    post("ign_reg2", 64'(regs[2]), 64'(32'hA5A5_0F0F));
    repeat (20) @(negedge clock);
    post("ign_frames", 64'(s_frames), 64'(n + 1));
    post("ign_cs_idle", 64'(cs0), 64'(1));

    // reset after the 20th SCK rising edge aborts the frame
    n = s_frames;
    c = rsp0_cnt;
    issue0(1'b0, 7'h04, 32'h1234_5678);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (s_bit == 20) ok = 1'b1;
      else @(negedge clock);
    end
    post("abort_sync", 64'(ok), 64'(1));
    reset = 1'b1;
    @(negedge clock);
    post("abort_cs_n", 64'(cs0), 64'(1));
    post("abort_sck", 64'(sck0), 64'(0));
    reset = 1'b0;
    @(negedge clock);
    post("abort_ready", 64'(bus0.cmd_ready), 64'(1));
    repeat (200) @(negedge clock);
    post("abort_no_rsp", 64'(rsp0_cnt), 64'(c));
    post("abort_frames", 64'(s_frames), 64'(n));
    post("abort_reg4", 64'(regs[4]), 64'(0));

    // normal read after the abort
    issue0(1'b1, 7'h02, 32'h0);
    wait_rsp0(d);
    post("rd2_rdata", 64'(d), 64'(32'hA5A5_0F0F));

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/pll_spi_master.md
PLL_SPI_MASTER -- requirements
Module: pll_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, SCK half-period in clock cycles; legal range 1..255.
REQ-002 SHALL have parameter CS_IDLE, default 4, minimum clock cycles spi_cs_n stays high between frames; legal range 1..255.
REQ-003 SHALL have one clock and a synchronous active-high reset.
REQ-004 clock  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  block idle and able to accept a command.
REQ-008 cmd_rw  input  1  1=read, 0=write.
REQ-009 cmd_addr  input  7  register address.
REQ-010 cmd_wdata  input  32  write data, ignored for reads.
REQ-011 rsp_valid  output  1  one-cycle pulse at frame completion.
REQ-012 rsp_rdata  output  32  read data, valid with rsp_valid.
REQ-013 busy  output  1  frame or CS guard time in progress.
REQ-014 spi_sck, spi_cs_n, spi_mosi  output  1 each  SPI mode 0 master lines.
REQ-015 spi_miso  input  1  slave data, changes on SCK falling edges.

Function
REQ-016 Handshake: a command SHALL be accepted on a clock edge with cmd_valid=1 and cmd_ready=1; cmd_rw, cmd_addr and cmd_wdata SHALL be captured on that edge; cmd_valid with cmd_ready=0 SHALL be ignored.
REQ-017 Frame SHALL be 40 bits, MSB first: {cmd_rw, cmd_addr[6:0], DATA[31:0]}; DATA=cmd_wdata for writes and 32'h0 for reads.
REQ-018 FSM states SHALL be IDLE, SETUP, SCK_HI, SCK_LO, HOLD and GUARD.
REQ-019 IDLE: cmd_ready=1, busy=0, spi_cs_n=1, spi_sck=0, spi_mosi=0; on acceptance go to SETUP.
REQ-020 SETUP: entered on the cycle after acceptance; spi_cs_n=0, spi_mosi=bit39; lasts CLK_DIV cycles, then SCK_HI.
REQ-021 SCK_HI: spi_sck=1 for CLK_DIV cycles; spi_miso SHALL be sampled on the clock edge that drives spi_sck 0->1.
REQ-022 SCK_LO: spi_sck=0 for CLK_DIV cycles; spi_mosi SHALL advance to the next bit on the same edge that drives spi_sck 1->0.
REQ-023 After the 40th SCK_HI/SCK_LO pair the FSM SHALL enter HOLD (spi_sck=0, spi_cs_n=0, spi_mosi=0) for CLK_DIV cycles; otherwise it returns to SCK_HI.
REQ-024 spi_cs_n SHALL be low for exactly 82*CLK_DIV cycles per frame (164 at default).
REQ-025 Leaving HOLD: spi_cs_n=1 and rsp_valid=1 for that single cycle; the FSM then stays in GUARD for CS_IDLE cycles in total, then returns to IDLE.
REQ-026 rsp_rdata SHALL hold the MISO samples from SCK rising edges 9..40, sample 9 in bit 31; for writes it SHALL be 32'h0; it SHALL hold its value until the next rsp_valid.
REQ-027 busy SHALL be 1 in every state except IDLE; cmd_ready SHALL equal ~busy.
REQ-028 Bit and half-period counters SHALL be sized for 40 bits and CLK_DIV=255 without wrap; no counter SHALL wrap within a frame.
REQ-029 Back-to-back: with cmd_valid held high, the next command SHALL be accepted on the first IDLE cycle, so spi_cs_n high time between frames is CS_IDLE+1 cycles.
REQ-030 spi_sck SHALL be 0 whenever spi_cs_n=1; all SPI outputs SHALL be driven directly from flops (glitch-free).

Reset
REQ-031 With reset=1 at a clock edge, the next cycle SHALL show: IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, rsp_valid=0, rsp_rdata=0, busy=0, cmd_ready=0 while reset is held.
REQ-032 cmd_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-033 Reset mid-frame SHALL abort the frame with no rsp_valid; the partial frame (fewer than 40 SCK edges) SHALL NOT commit a write in the slave.

Verification
REQ-034 Write cmd_addr=7'h00, cmd_wdata=32'h0000_0015, CLK_DIV=2 -> MOSI stream 8'h00 then 32'h0000_0015; spi_cs_n low exactly 164 cycles; slave model div=5, enable=1.
REQ-035 Read cmd_addr=7'h01, slave model returns 32'h02AB_CDEF -> address byte 8'h81, rsp_valid pulse with rsp_rdata=32'h02AB_CDEF.
REQ-036 CLK_DIV=1, CS_IDLE=4, cmd_valid held for two writes -> spi_cs_n low 82 cycles per frame and high exactly 5 cycles between frames.
REQ-037 reset pulsed after the 20th SCK rising edge -> spi_cs_n=1 and spi_sck=0 on the next cycle, no rsp_valid, slave registers unchanged.
REQ-038 cmd_valid pulsed with new values while busy=1 -> command ignored; in-flight frame bits and rsp_rdata unaffected.
